// File: rtl/snake_pkg.sv
// Shared codes for the snake game: committed directions and game phases.
// Direction codes are chosen so that the opposite direction is a flip of bit 1.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } state_e;

  function automatic dir_e reverse_dir(input dir_e d);
    return dir_e'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/game_sequencer_move_tick_gen.sv
// Move-rate divider: counts 0..TICK_DIV-1 while enabled and emits a registered
// one-cycle tick on the wrap edge; at_max lets the parent act on that same edge.
module move_tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic at_max,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  assign at_max = (cnt_q == CNT_MAX);
  assign tick   = tick_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      tick_d = at_max;
      cnt_d  = at_max ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Snake game master controller: phase FSM, move strobe, button arbitration
// into one committed direction per move (no reversal), and score keeping.
module game_sequencer
  import snake_pkg::*;
#(
  parameter int TICK_DIV     = 25000000,
  parameter int SCORE_TARGET = 10
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LEFT,
  input  logic       RIGHT,
  input  logic       UP,
  input  logic       DOWN,
  input  logic       COLLISION,
  input  logic       TARGET_EATEN,
  output logic       MOVE_TICK,
  output logic [1:0] DIRECTION,
  output logic       SNAKE_INIT,
  output logic [1:0] GAME_STATE,
  output logic [3:0] SCORE
);

  localparam logic [3:0] SCORE_WIN = 4'(SCORE_TARGET);

  state_e     state_q, state_d;
  dir_e       dir_q, dir_d;
  dir_e       pend_q, pend_d;
  logic [3:0] score_q, score_d;
  logic       snake_init_q, snake_init_d;
  logic [3:0] btn_prev_q, btn_prev_d;

  logic [3:0] btn, press;
  logic       any_press;
  dir_e       press_dir;
  logic       stay_play;
  logic       at_max;

  // Bit order {UP, DOWN, LEFT, RIGHT} matches the press priority.
  assign btn       = {UP, DOWN, LEFT, RIGHT};
  assign press     = btn & ~btn_prev_q;
  assign any_press = |press;

  always_comb begin
    press_dir = DIR_RIGHT;
    if      (press[3]) press_dir = DIR_UP;
    else if (press[2]) press_dir = DIR_DOWN;
    else if (press[1]) press_dir = DIR_LEFT;
  end

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    pend_d       = pend_q;
    score_d      = score_q;
    snake_init_d = 1'b0;
    btn_prev_d   = btn;

    case (state_q)
      ST_IDLE: begin
        if (any_press) begin
          state_d      = ST_PLAY;
          score_d      = '0;
          dir_d        = press_dir;
          pend_d       = press_dir;
          snake_init_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (any_press && (press_dir != reverse_dir(dir_q))) pend_d = press_dir;
        // Collision takes precedence over a simultaneous eat.
        if (COLLISION) begin
          state_d = ST_LOSE;
        end else if (TARGET_EATEN) begin
          score_d = score_q + 4'd1;
          if (score_d == SCORE_WIN) state_d = ST_WIN;
        end
      end
      default: begin
        if (any_press) state_d = ST_IDLE;
      end
    endcase

    // The tick only fires while play continues, so leaving PLAY freezes direction.
    stay_play = (state_q == ST_PLAY) && (state_d == ST_PLAY);
    if (stay_play && at_max) dir_d = pend_d;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      dir_q        <= DIR_RIGHT;
      pend_q       <= DIR_RIGHT;
      score_q      <= '0;
      snake_init_q <= 1'b0;
      btn_prev_q   <= '0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      pend_q       <= pend_d;
      score_q      <= score_d;
      snake_init_q <= snake_init_d;
      btn_prev_q   <= btn_prev_d;
    end
  end

  move_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (CLK),
    .rst    (RESET),
    .en     (stay_play),
    .clr    (!stay_play),
    .at_max (at_max),
    .tick   (MOVE_TICK)
  );

  assign DIRECTION  = dir_q;
  assign GAME_STATE = state_q;
  assign SCORE      = score_q;
  assign SNAKE_INIT = snake_init_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with TICK_DIV=4 and SCORE_TARGET=3;
// expected values are hand-derived edge by edge from the game rules.
module tb_game_sequencer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       LEFT = 1'b0, RIGHT = 1'b0, UP = 1'b0, DOWN = 1'b0;
  logic       COLLISION = 1'b0, TARGET_EATEN = 1'b0;
  logic       MOVE_TICK, SNAKE_INIT;
  logic [1:0] DIRECTION, GAME_STATE;
  logic [3:0] SCORE;

  int checks = 0;
  int errors = 0;
  int ticks;

  game_sequencer #(.TICK_DIV(4), .SCORE_TARGET(3)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .LEFT         (LEFT),
    .RIGHT        (RIGHT),
    .UP           (UP),
    .DOWN         (DOWN),
    .COLLISION    (COLLISION),
    .TARGET_EATEN (TARGET_EATEN),
    .MOVE_TICK    (MOVE_TICK),
    .DIRECTION    (DIRECTION),
    .SNAKE_INIT   (SNAKE_INIT),
    .GAME_STATE   (GAME_STATE),
    .SCORE        (SCORE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [1:0] dir,
                           input logic [3:0] sc, input logic mt, input logic si);
    check({tag, ".state"},      8'(GAME_STATE), 8'(st));
    check({tag, ".direction"},  8'(DIRECTION),  8'(dir));
    check({tag, ".score"},      8'(SCORE),      8'(sc));
    check({tag, ".move_tick"},  8'(MOVE_TICK),  8'(mt));
    check({tag, ".snake_init"}, 8'(SNAKE_INIT), 8'(si));
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset state, then 50 idle cycles with no buttons.
    repeat (3) step();
    check_all("reset", 2'd0, 2'd1, 4'd0, 1'b0, 1'b0);
    RESET = 1'b0;
    ticks = 0;
    repeat (50) begin
      step();
      if (MOVE_TICK === 1'b1) ticks++;
    end
    check("idle_no_tick", 8'(ticks), 8'd0);
    check_all("idle50", 2'd0, 2'd1, 4'd0, 1'b0, 1'b0);

    // UP starts a game; ticks land on PLAY cycles 4 and 8.
    UP = 1'b1; step(); UP = 1'b0;
    check_all("start_up", 2'd1, 2'd0, 4'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("tick_cycle%0d", k), 8'(MOVE_TICK), (k % 4 == 0) ? 8'd1 : 8'd0);
      if (k == 1) check("snake_init_one_cycle", 8'(SNAKE_INIT), 8'd0);
    end

    // Commit RIGHT, then LEFT (reverse) followed by UP: UP wins at the tick.
    RIGHT = 1'b1; step(); RIGHT = 1'b0;
    repeat (3) step();
    check("commit_right.tick", 8'(MOVE_TICK), 8'd1);
    check("commit_right.dir",  8'(DIRECTION), 8'd1);
    LEFT = 1'b1; step(); LEFT = 1'b0;
    check("left_between_ticks.dir", 8'(DIRECTION), 8'd1);
    UP = 1'b1; step(); UP = 1'b0;
    repeat (2) step();
    check("left_then_up.tick", 8'(MOVE_TICK), 8'd1);
    check("left_then_up.dir",  8'(DIRECTION), 8'd0);

    // DOWN against committed UP is a reversal and is dropped.
    DOWN = 1'b1; step(); DOWN = 1'b0;
    repeat (3) step();
    check("down_vs_up.tick", 8'(MOVE_TICK), 8'd1);
    check("down_vs_up.dir",  8'(DIRECTION), 8'd0);

    // LEFT alone against committed RIGHT is dropped too.
    RIGHT = 1'b1; step(); RIGHT = 1'b0;
    repeat (3) step();
    check("recommit_right.dir", 8'(DIRECTION), 8'd1);
    LEFT = 1'b1; step(); LEFT = 1'b0;
    repeat (3) step();
    check("left_vs_right.tick", 8'(MOVE_TICK), 8'd1);
    check("left_vs_right.dir",  8'(DIRECTION), 8'd1);

    // Three eats reach SCORE_TARGET and win; ticks stop.
    TARGET_EATEN = 1'b1;
    step(); check_all("eat1", 2'd1, 2'd1, 4'd1, 1'b0, 1'b0);
    step(); check_all("eat2", 2'd1, 2'd1, 4'd2, 1'b0, 1'b0);
    step(); TARGET_EATEN = 1'b0;
    check_all("eat3_win", 2'd2, 2'd1, 4'd3, 1'b0, 1'b0);
    ticks = 0;
    repeat (6) begin
      step();
      if (MOVE_TICK === 1'b1) ticks++;
    end
    check("win_no_tick", 8'(ticks), 8'd0);
    COLLISION = 1'b1; step(); COLLISION = 1'b0;
    check_all("win_ignores_collision", 2'd2, 2'd1, 4'd3, 1'b0, 1'b0);
    LEFT = 1'b1; step(); LEFT = 1'b0;
    check_all("win_to_idle", 2'd0, 2'd1, 4'd3, 1'b0, 1'b0);

    // New game; collision and eat together at SCORE=1 loses without scoring.
    RIGHT = 1'b1; step(); RIGHT = 1'b0;
    check_all("restart", 2'd1, 2'd1, 4'd0, 1'b0, 1'b1);
    TARGET_EATEN = 1'b1; step(); TARGET_EATEN = 1'b0;
    check("score_one", 8'(SCORE), 8'd1);
    COLLISION = 1'b1; TARGET_EATEN = 1'b1; step();
    COLLISION = 1'b0; TARGET_EATEN = 1'b0;
    check_all("collide_and_eat", 2'd3, 2'd1, 4'd1, 1'b0, 1'b0);
    TARGET_EATEN = 1'b1; step(); TARGET_EATEN = 1'b0;
    check_all("lose_ignores_eat", 2'd3, 2'd1, 4'd1, 1'b0, 1'b0);

    // LOSE -> IDLE -> PLAY, then asynchronous reset during a tick cycle.
    DOWN = 1'b1; step(); DOWN = 1'b0;
    check_all("lose_to_idle", 2'd0, 2'd1, 4'd1, 1'b0, 1'b0);
    UP = 1'b1; step(); UP = 1'b0;
    check_all("play2", 2'd1, 2'd0, 4'd0, 1'b0, 1'b1);
    TARGET_EATEN = 1'b1; step(); TARGET_EATEN = 1'b0;
    repeat (3) step();
    check_all("play2_tick", 2'd1, 2'd0, 4'd1, 1'b1, 1'b0);
    #3;
    RESET = 1'b1;
    RIGHT = 1'b1;
    #1;
    check_all("async_reset", 2'd0, 2'd1, 4'd0, 1'b0, 1'b0);
    step();
    check_all("reset_held", 2'd0, 2'd1, 4'd0, 1'b0, 1'b0);
    RESET = 1'b0;
    step();
    check_all("held_right_start", 2'd1, 2'd1, 4'd0, 1'b0, 1'b1);
    step();
    check_all("held_right_no_repress", 2'd1, 2'd1, 4'd0, 1'b0, 1'b0);
    RIGHT = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
